bean_tracker: RTL

BEAN_TRACKER -- requirements
Module: bean_tracker

---
 rtl/pac_pkg.sv | 65 ++++++
 rtl/ghost_hit.sv | 25 ++
 rtl/bean_tracker.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/pac_pkg.sv
// Shared constants for the bean tracker: maze layout, bean count, FSM encoding
// and the coordinate/score widths used by the tracker and its collision checker.
package pac_pkg;

  // Playfield geometry of the stock layout (16-pixel tiles over 640x480).
  localparam int LAYOUT_COLS = 40;
  localparam int LAYOUT_ROWS = 30;
  localparam int BEAN_BITS   = LAYOUT_COLS * LAYOUT_ROWS;
  localparam int TILE_SHIFT  = 4;

  // Datapath widths.
  localparam int X_W        = 10;  // pixel column
  localparam int Y_W        = 9;   // pixel row
  localparam int IDX_W      = 11;  // flat tile index, also wide enough for the centre column
  localparam int SCORE_W    = 16;
  localparam int LEFT_W     = 11;  // beans remaining
  localparam int NUM_GHOSTS = 4;

  localparam logic [SCORE_W-1:0] SCORE_STEP = 16'd10;
  localparam logic [SCORE_W-1:0] SCORE_MAX  = 16'hFFFF;

  // Game state: PLAY while running, WIN/LOSE are terminal until restart.
  typedef enum logic [1:0] {
    ST_PLAY = 2'd0,
    ST_WIN  = 2'd1,
    ST_LOSE = 2'd2
  } state_t;

  // Maze walls: a solid border plus a regular grid of interior pillars.
  // The border also keeps every bean reachable, since the Pac centre tile
  // can never fall on column 0 or row 0.
  function automatic bit is_wall(int row, int col);
    return (row == 0) || (row == LAYOUT_ROWS - 1) ||
           (col == 0) || (col == LAYOUT_COLS - 1) ||
           ((row % 4 == 2) && (col % 5 == 2));
  endfunction

  // Build the initial bean bitmap: a bean on every non-wall tile.
  function automatic logic [BEAN_BITS-1:0] build_layout();
    logic [BEAN_BITS-1:0] m;
    m = '0;
    for (int r = 0; r < LAYOUT_ROWS; r++) begin
      for (int c = 0; c < LAYOUT_COLS; c++) begin
        m[IDX_W'(r * LAYOUT_COLS + c)] = is_wall(r, c) ? 1'b0 : 1'b1;
      end
    end
    return m;
  endfunction

  // Popcount of a bitmap, walked row by row.
  function automatic logic [LEFT_W-1:0] count_beans(logic [BEAN_BITS-1:0] m);
    int n;
    n = 0;
    for (int r = 0; r < LAYOUT_ROWS; r++) begin
      for (int c = 0; c < LAYOUT_COLS; c++) begin
        if (m[IDX_W'(r * LAYOUT_COLS + c)]) n++;
      end
    end
    return LEFT_W'(n);
  endfunction

  localparam logic [BEAN_BITS-1:0] BEAN_INIT       = build_layout();
  localparam logic [LEFT_W-1:0]    BEAN_INIT_COUNT = count_beans(BEAN_INIT);

endpackage

// File: rtl/ghost_hit.sv
// Combinational Pac/ghost overlap test: both axis distances below HIT_DIST.
module ghost_hit
  import pac_pkg::*;
#(
  parameter int HIT_DIST = 24
) (
  input  logic [X_W-1:0] pac_x,
  input  logic [Y_W-1:0] pac_y,
  input  logic [X_W-1:0] ghost_x,
  input  logic [Y_W-1:0] ghost_y,
  output logic           hit
);

  logic [X_W-1:0] dx;
  logic [Y_W-1:0] dy;

  // Absolute differences on each axis, compared against the hit distance.
  always_comb begin
    dx  = (pac_x >= ghost_x) ? (pac_x - ghost_x) : (ghost_x - pac_x);
    dy  = (pac_y >= ghost_y) ? (pac_y - ghost_y) : (ghost_y - pac_y);
    hit = ({1'b0, dx} < IDX_W'(HIT_DIST)) &&
          ({2'b00, dy} < IDX_W'(HIT_DIST));
  end

endmodule

// File: rtl/bean_tracker.sv
// Bean tracker: on each game tick, detects Pac/ghost collisions, eats the bean
// under the Pac centre tile, keeps score and decides win/lose.
module bean_tracker
  import pac_pkg::*;
#(
  parameter int MAP_COLS = 40,
  parameter int MAP_ROWS = 30,
  parameter int HIT_DIST = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 restart,
  input  logic [X_W-1:0]       PacX,
  input  logic [Y_W-1:0]       PacY,
  input  logic [X_W-1:0]       Ghost1X,
  input  logic [X_W-1:0]       Ghost2X,
  input  logic [X_W-1:0]       Ghost3X,
  input  logic [X_W-1:0]       Ghost4X,
  input  logic [Y_W-1:0]       Ghost1Y,
  input  logic [Y_W-1:0]       Ghost2Y,
  input  logic [Y_W-1:0]       Ghost3Y,
  input  logic [Y_W-1:0]       Ghost4Y,
  output logic [BEAN_BITS-1:0] beanmap,
  output logic                 over,
  output logic                 win,
  output logic [SCORE_W-1:0]   score,
  output logic                 eat
);

  // Registered state and its next values.
  state_t               state_reg, state_next;
  logic [BEAN_BITS-1:0] beanmap_reg, beanmap_next;
  logic [LEFT_W-1:0]    beans_left_reg, beans_left_next;
  logic [SCORE_W-1:0]   score_reg, score_next;
  logic                 eat_reg, eat_next;
  logic                 over_reg, win_reg;

  // Ghost positions gathered into arrays so the checkers can be generated.
  logic [X_W-1:0]        ghost_x [NUM_GHOSTS];
  logic [Y_W-1:0]        ghost_y [NUM_GHOSTS];
  logic [NUM_GHOSTS-1:0] hit_vec;
  logic                  any_hit;

  // Tile lookup.
  logic [IDX_W-1:0]     tile_col;
  logic [IDX_W-2:0]     tile_row;
  logic                 in_range;
  logic [IDX_W-1:0]     bean_idx;
  logic                 bean_here;
  logic                 play_tick;
  logic                 eat_fire;
  logic [BEAN_BITS-1:0] clear_mask;
  logic [SCORE_W:0]     score_sum;

  assign ghost_x[0] = Ghost1X;
  assign ghost_x[1] = Ghost2X;
  assign ghost_x[2] = Ghost3X;
  assign ghost_x[3] = Ghost4X;
  assign ghost_y[0] = Ghost1Y;
  assign ghost_y[1] = Ghost2Y;
  assign ghost_y[2] = Ghost3Y;
  assign ghost_y[3] = Ghost4Y;

  // One overlap checker per ghost; any hit ends the game.
  for (genvar gi = 0; gi < NUM_GHOSTS; gi++) begin : g_hit
    ghost_hit #(
      .HIT_DIST (HIT_DIST)
    ) u_ghost_hit (
      .pac_x   (PacX),
      .pac_y   (PacY),
      .ghost_x (ghost_x[gi]),
      .ghost_y (ghost_y[gi]),
      .hit     (hit_vec[gi])
    );
  end

  assign any_hit = |hit_vec;

  // Centre tile of the Pac sprite, its flat index and whether it holds a bean.
  // Off-map tiles force the index to 0 and are masked out by in_range.
  always_comb begin
    tile_col  = (IDX_W'(PacX) + IDX_W'(16)) >> TILE_SHIFT;
    tile_row  = ((IDX_W-1)'(PacY) + (IDX_W-1)'(16)) >> TILE_SHIFT;
    in_range  = (tile_col < IDX_W'(MAP_COLS)) && (tile_row < (IDX_W-1)'(MAP_ROWS));
    bean_idx  = in_range ? (IDX_W'(tile_row) * IDX_W'(MAP_COLS) + tile_col) : '0;
    bean_here = in_range && beanmap_reg[bean_idx];
  end

  // A tick only counts in PLAY and when no restart competes with it;
  // a collision on the same tick suppresses the eat.
  always_comb begin
    play_tick = tick && !restart && (state_reg == ST_PLAY);
    eat_fire  = play_tick && !any_hit && bean_here;
  end

  // One-hot clear of the eaten bean.
  for (genvar gi = 0; gi < BEAN_BITS; gi++) begin : g_clear
    assign clear_mask[gi] = eat_fire && (bean_idx == IDX_W'(gi));
  end

  // FSM next-state: restart from anywhere, collision loses, last bean wins.
  always_comb begin
    state_next = state_reg;
    if (restart) begin
      state_next = ST_PLAY;
    end else if (play_tick) begin
      if (any_hit) begin
        state_next = ST_LOSE;
      end else if (eat_fire && (beans_left_reg == LEFT_W'(1))) begin
        state_next = ST_WIN;
      end
    end
  end

  // Datapath next values: restart reload, or bean clear/score/count on an eat.
  always_comb begin
    beanmap_next    = beanmap_reg;
    beans_left_next = beans_left_reg;
    score_next      = score_reg;
    eat_next        = 1'b0;
    score_sum       = {1'b0, score_reg} + {1'b0, SCORE_STEP};
    if (restart) begin
      beanmap_next    = BEAN_INIT;
      beans_left_next = BEAN_INIT_COUNT;
      score_next      = '0;
    end else if (eat_fire) begin
      beanmap_next = beanmap_reg & ~clear_mask;
      if (beans_left_reg != '0) begin
        beans_left_next = beans_left_reg - LEFT_W'(1);
      end
      score_next = score_sum[SCORE_W] ? SCORE_MAX : score_sum[SCORE_W-1:0];
      eat_next   = 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_PLAY;
    end else begin
      state_reg <= state_next;
    end
  end

  // Datapath and output registers; over/win follow the next state so they
  // rise together with the eat pulse or the collision that caused them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beanmap_reg    <= BEAN_INIT;
      beans_left_reg <= BEAN_INIT_COUNT;
      score_reg      <= '0;
      eat_reg        <= 1'b0;
      over_reg       <= 1'b0;
      win_reg        <= 1'b0;
    end else begin
      beanmap_reg    <= beanmap_next;
      beans_left_reg <= beans_left_next;
      score_reg      <= score_next;
      eat_reg        <= eat_next;
      over_reg       <= (state_next != ST_PLAY);
      win_reg        <= (state_next == ST_WIN);
    end
  end

  assign beanmap = beanmap_reg;
  assign score   = score_reg;
  assign eat     = eat_reg;
  assign over    = over_reg;
  assign win     = win_reg;

endmodule
